// File: rtl/dvbc_ts_sync.sv
// dvbc_ts_sync: recovers the 188-byte TS packet grid from an unframed byte stream
// and forwards framed packets through a first-word fall-through output FIFO.
module dvbc_ts_sync #(
    parameter int PACKET_LEN   = 188,
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 3,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_i,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic [7:0] tsp_data,
    output logic       tsp_sync,
    output logic       tsp_valid,
    input  logic       tsp_ack,
    output logic       lock_o,
    output logic [2:0] grp_idx_o,
    output logic       ovf_o
);
    localparam int PW = $clog2(PACKET_LEN);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pos, pos_n, pos_inc;
    logic [2:0]      good, good_n, miss, miss_n, grp, grp_n;
    logic            is_sync, at_sof, push_req, push, pop, drop, full;
    logic [8:0]      push_word;
    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    assign is_sync   = byte_i == 8'h47 || byte_i == 8'hB8;
    assign at_sof    = pos == '0;
    assign pos_inc   = pos == PW'(PACKET_LEN - 1) ? '0 : pos + 1'b1;
    // every sync slot, including flywheeled ones, is regenerated as 0x47
    assign push_word = at_sof ? 9'h147 : {1'b0, byte_i};
    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign tsp_valid = count != '0;
    assign pop       = tsp_valid && tsp_ack;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign tsp_data  = tsp_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign tsp_sync  = tsp_valid && mem[rd_ptr][8];
    assign lock_o    = state == LOCK;
    assign grp_idx_o = grp;

    always_comb begin
        state_n  = state;
        pos_n    = pos;
        good_n   = good;
        miss_n   = miss;
        grp_n    = grp;
        push_req = 1'b0;
        if (byte_valid_i) begin
            case (state)
                SEARCH: if (is_sync) begin
                    state_n = VERIFY;
                    pos_n   = PW'(1);
                    good_n  = 3'd1;
                end
                VERIFY: begin
                    pos_n = pos_inc;
                    if (at_sof) begin
                        if (!is_sync) state_n = SEARCH;
                        else if (good + 3'd1 == 3'(LOCK_COUNT)) begin
                            state_n  = LOCK;
                            miss_n   = 3'd0;
                            push_req = 1'b1;
                            grp_n    = byte_i == 8'hB8 ? 3'd0 : grp;
                        end else good_n = good + 3'd1;
                    end
                end
                LOCK: begin
                    pos_n    = pos_inc;
                    push_req = 1'b1;
                    if (at_sof) begin
                        grp_n  = byte_i == 8'hB8 ? 3'd0 : grp + 3'd1;
                        miss_n = is_sync ? 3'd0 : miss + 3'd1;
                        if (!is_sync && miss + 3'd1 == 3'(UNLOCK_COUNT)) begin
                            state_n  = SEARCH;
                            push_req = 1'b0;
                            grp_n    = grp;
                        end
                    end
                end
                default: state_n = SEARCH;
            endcase
            if (push_req && full && !pop) state_n = SEARCH;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state  <= SEARCH;
            pos    <= '0;
            good   <= '0;
            miss   <= '0;
            grp    <= '0;
            ovf_o  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            good   <= good_n;
            miss   <= miss_n;
            grp    <= grp_n;
            ovf_o  <= ovf_o | drop;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (push) mem[wr_ptr] <= push_word;
    end
endmodule
